// File: rtl/log_drain.sv
// log_drain: captures logger entries into a small FIFO and streams each one
// out as an 8-byte frame (A5, addr hi/lo, data[36:32], data[31:0] MSB first)
// over a valid/ready byte port. The logger can never stall, so a full FIFO
// drops the entry and counts it instead of back-pressuring.
module log_drain #(
    parameter int DEPTH = 8,
    parameter int LVL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             log_we,
    input  logic [15:0]      log_addr,
    input  logic [36:0]      log_data,
    input  logic             clr,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic [15:0]      drop_cnt,
    output logic             overflow
);
    localparam int AW = LVL_W - 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    // Entry layout: {addr[15:0], data[36:0]}
    function automatic logic [7:0] frame_byte(input logic [52:0] e, input logic [2:0] k);
        logic [7:0] b;
        unique case (k)
            3'd0:    b = 8'hA5;
            3'd1:    b = e[52:45];
            3'd2:    b = e[44:37];
            3'd3:    b = {3'b000, e[36:32]};
            3'd4:    b = e[31:24];
            3'd5:    b = e[23:16];
            3'd6:    b = e[15:8];
            default: b = e[7:0];
        endcase
        return b;
    endfunction

    logic             we_d;
    logic [15:0]      addr_d;
    logic [52:0]      mem [DEPTH];
    logic [LVL_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [52:0]      head;
    logic [52:0]      shreg;
    logic [2:0]       idx;
    logic [0:0]       state;
    logic             full, empty, hs, pop, push, push_ok, drop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign hs    = tx_valid && tx_ready;

    // Pop loads the serializer: from IDLE, or on the last handshake of a
    // frame for gapless output. clr empties the FIFO, so nothing is popped.
    assign pop = !clr && !empty &&
                 ((state == S_IDLE) || (state == S_SEND && hs && idx == 3'd7));

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push    = we_d && !clr;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    assign wr_nxt = push_ok ? wr_ptr + LVL_W'(1) : wr_ptr;
    assign rd_nxt = pop     ? rd_ptr + LVL_W'(1) : rd_ptr;

    // Capture stage: address arrives with the strobe, data one cycle later.
    // clr drops whatever is in flight here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_d   <= 1'b0;
            addr_d <= '0;
        end else begin
            we_d   <= log_we && !clr;
            addr_d <= log_addr;
        end
    end

    // Entry storage; the read of the head slot sees the old value when a
    // push lands on the same slot as a pop.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= {addr_d, log_data};
    end

    // Pointers and level, kept in step so level is a plain register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            fifo_level <= wr_nxt - rd_nxt;
        end
    end

    // Drop accounting: saturating counter plus sticky flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            overflow <= 1'b1;
        end
    end

    // Serializer: registered byte/valid, held while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            shreg    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (pop) begin
            state    <= S_SEND;
            shreg    <= head;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= 8'hA5;
        end else if (state == S_SEND && hs) begin
            if (idx == 3'd7) begin
                state    <= S_IDLE;
                idx      <= '0;
                tx_valid <= 1'b0;
                tx_data  <= '0;
            end else begin
                idx     <= idx + 3'd1;
                tx_data <= frame_byte(shreg, idx + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_log_drain.sv
// Bench for log_drain: directed scenarios plus randomized traffic checked
// against a queue-level model of capture, FIFO and frame output.
module tb_log_drain;
    localparam int DEPTH = 8;
    localparam int LVL_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             log_we = 1'b0;
    logic [15:0]      log_addr = '0;
    logic [36:0]      log_data = '0;
    logic             clr = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic [LVL_W-1:0] fifo_level;
    logic [15:0]      drop_cnt;
    logic             overflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    log_drain #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .reset(reset), .log_we(log_we), .log_addr(log_addr),
        .log_data(log_data), .clr(clr), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .fifo_level(fifo_level), .drop_cnt(drop_cnt),
        .overflow(overflow)
    );

    // Reference model: pending capture, entry queue, remaining frame bytes
    bit          m_we_d;
    logic [15:0] m_addr_d;
    logic [52:0] mq[$];
    logic [7:0]  mcur[$];
    int          m_drop;
    bit          m_ovf;

    function automatic logic [7:0] fbyte(input logic [15:0] a, input logic [36:0] d, input int k);
        logic [63:0] f;
        f = {8'hA5, a, 3'b000, d};
        return f[63-8*k -: 8];
    endfunction

    function automatic void model_reset();
        m_we_d = 1'b0; m_addr_d = '0; mq.delete(); mcur.delete(); m_drop = 0; m_ovf = 0;
    endfunction

    function automatic void model_step();
        logic [52:0] h;
        if (mcur.size() != 0 && tx_ready) void'(mcur.pop_front());
        if (mcur.size() == 0 && !clr && mq.size() != 0) begin
            h = mq.pop_front();
            for (int k = 0; k < 8; k++) mcur.push_back(fbyte(h[52:37], h[36:0], k));
        end
        if (clr) begin
            mq.delete(); m_drop = 0; m_ovf = 0;
        end else if (m_we_d) begin
            if (mq.size() < DEPTH) mq.push_back({m_addr_d, log_data});
            else begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1;
            end
        end
        m_we_d   = log_we && !clr;
        m_addr_d = log_addr;
    endfunction

    // Advance one clock; inputs were set at the preceding negedge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        log_we = 0; clr = 0; tx_ready = 0; log_addr = '0; log_data = '0;
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset tx_data got %h want 00", tx_data); end
        n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset tx_valid got %b want 0", tx_valid); end
        n_chk++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset fifo_level got %0d want 0", fifo_level); end
        n_chk++; if (drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset drop_cnt got %0d want 0", drop_cnt); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset overflow got %b want 0", overflow); end
    endtask

    task automatic test_single();
        logic [7:0] exp [8] = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
        do_reset();
        tx_ready = 1;
        log_we = 1; log_addr = 16'h0003; tick();             // now N+1
        log_we = 0; log_data = 37'h1_2345_6789; tick();      // now N+2
        log_data = '0;
        n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL single early_valid got %b want 0", tx_valid); end
        n_chk++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL single level_n2 got %0d want 1", fifo_level); end
        tick();                                              // now N+3
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (tx_valid !== 1'b1 || tx_data !== exp[k]) begin
                n_fail++; $display("FAIL single byte%0d got v=%b %h want v=1 %h", k, tx_valid, tx_data, exp[k]);
            end
            tick();
        end
        n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL single end_valid got %b want 0", tx_valid); end
        n_chk++; if (fifo_level !== '0) begin n_fail++; $display("FAIL single end_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_backpressure();
        int w;
        logic [36:0] d;
        d = 37'h1F_DEAD_BEEF;
        do_reset();
        tx_ready = 0;
        log_we = 1; log_addr = 16'hBEEF; tick();
        log_we = 0; log_data = d; tick();
        w = 0;
        while (!tx_valid && w < 10) begin tick(); w++; end
        n_chk++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL backpressure timeout tx_valid got %b want 1", tx_valid); end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
                n_fail++; $display("FAIL backpressure hold%0d got v=%b %h want v=1 a5", i, tx_valid, tx_data);
            end
            tick();
        end
        tx_ready = 1;
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (tx_valid !== 1'b1 || tx_data !== fbyte(16'hBEEF, d, k)) begin
                n_fail++; $display("FAIL backpressure byte%0d got v=%b %h want v=1 %h", k, tx_valid, tx_data, fbyte(16'hBEEF, d, k));
            end
            tick();
        end
        n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure end_valid got %b want 0", tx_valid); end
    endtask

    task automatic test_overflow();
        logic [36:0] d [11];
        logic [7:0]  got[$];
        do_reset();
        tx_ready = 0;
        for (int i = 0; i < 11; i++) d[i] = {5'($urandom), 32'($urandom)};
        for (int i = 0; i < 12; i++) begin
            log_we = (i < 11); log_addr = 16'h0100 + 16'(i);
            if (i > 0) log_data = d[i-1];
            tick();
        end
        log_we = 0; tick(); tick();
        n_chk++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL overflow level got %0d want 8", fifo_level); end
        n_chk++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL overflow drop_cnt got %0d want 2", drop_cnt); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow flag got %b want 1", overflow); end
        tx_ready = 1;
        for (int w = 0; w < 120 && got.size() < 72; w++) begin
            if (tx_valid && tx_ready) got.push_back(tx_data);
            tick();
        end
        n_chk++; if (got.size() != 72) begin n_fail++; $display("FAIL overflow drained_bytes got %0d want 72", got.size()); end
        if (got.size() == 72) begin
            for (int f = 0; f < 9; f++)
                for (int k = 0; k < 8; k++) begin
                    n_chk++;
                    if (got[f*8+k] !== fbyte(16'h0100 + 16'(f), d[f], k)) begin
                        n_fail++; $display("FAIL overflow frame%0d byte%0d got %h want %h", f, k, got[f*8+k], fbyte(16'h0100 + 16'(f), d[f], k));
                    end
                end
        end
        n_chk++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL overflow drop_after got %0d want 2", drop_cnt); end
    endtask

    task automatic test_full_pop();
        logic [7:0] got[$];
        do_reset();
        tx_ready = 0;
        for (int i = 0; i < 10; i++) begin
            log_we = (i < 9); log_addr = 16'h0300 + 16'(i);
            log_data = 37'(i);
            tick();
        end
        log_we = 0; tick();
        n_chk++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_pop pre_level got %0d want 8", fifo_level); end
        // last handshake of the 0x300 frame lands on the 8th edge; push it there
        tx_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            log_we = (k == 7); log_addr = 16'h0399;
            if (k == 8) log_data = 37'h42;
            tick();
        end
        log_we = 0;
        n_chk++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_pop level got %0d want 8", fifo_level); end
        n_chk++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL full_pop drop_cnt got %0d want 0", drop_cnt); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pop overflow got %b want 0", overflow); end
        n_chk++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin n_fail++; $display("FAIL full_pop next_sync got v=%b %h want v=1 a5", tx_valid, tx_data); end
        for (int w = 0; w < 120 && got.size() < 72; w++) begin
            if (tx_valid && tx_ready) got.push_back(tx_data);
            tick();
        end
        n_chk++; if (got.size() != 72) begin n_fail++; $display("FAIL full_pop drained_bytes got %0d want 72", got.size()); end
        if (got.size() == 72) begin
            n_chk++; if (got[2] !== 8'h01) begin n_fail++; $display("FAIL full_pop head_addr got %h want 01", got[2]); end
            n_chk++; if (got[66] !== 8'h99) begin n_fail++; $display("FAIL full_pop last_addr got %h want 99", got[66]); end
            n_chk++; if (got[71] !== 8'h42) begin n_fail++; $display("FAIL full_pop last_data got %h want 42", got[71]); end
        end
    endtask

    task automatic test_clear();
        logic [36:0] d [5];
        do_reset();
        tx_ready = 0;
        for (int i = 0; i < 5; i++) d[i] = {5'($urandom), 32'($urandom)};
        for (int i = 0; i < 6; i++) begin
            log_we = (i < 5); log_addr = 16'h0400 + 16'(i);
            if (i > 0) log_data = d[i-1];
            tick();
        end
        log_we = 0; tick();
        n_chk++; if (fifo_level !== 4'd4) begin n_fail++; $display("FAIL clear pre_level got %0d want 4", fifo_level); end
        tx_ready = 1;
        tick(); tick(); tick();
        n_chk++; if (tx_data !== fbyte(16'h0400, d[0], 3)) begin n_fail++; $display("FAIL clear idx3 got %h want %h", tx_data, fbyte(16'h0400, d[0], 3)); end
        clr = 1; tick(); clr = 0;
        n_chk++; if (fifo_level !== '0) begin n_fail++; $display("FAIL clear level got %0d want 0", fifo_level); end
        n_chk++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL clear drop_cnt got %0d want 0", drop_cnt); end
        for (int k = 4; k < 8; k++) begin
            n_chk++;
            if (tx_valid !== 1'b1 || tx_data !== fbyte(16'h0400, d[0], k)) begin
                n_fail++; $display("FAIL clear byte%0d got v=%b %h want v=1 %h", k, tx_valid, tx_data, fbyte(16'h0400, d[0], k));
            end
            tick();
        end
        tick();
        n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL clear end_valid got %b want 0", tx_valid); end
    endtask

    task automatic test_async_reset();
        logic [36:0] d;
        d = 37'h15_5555_AAAA;
        do_reset();
        tx_ready = 1;
        log_we = 1; log_addr = 16'h0500; tick();
        log_addr = 16'h0501; log_data = 37'h11; tick();
        log_we = 0; log_data = 37'h22; tick();
        tick();
        n_chk++; if (tx_valid !== 1'b1 || fifo_level !== 4'd1) begin n_fail++; $display("FAIL async_reset midframe got v=%b lvl=%0d want v=1 lvl=1", tx_valid, fifo_level); end
        #2 reset = 1;
        #1;
        n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset tx_valid got %b want 0", tx_valid); end
        n_chk++; if (fifo_level !== '0) begin n_fail++; $display("FAIL async_reset level got %0d want 0", fifo_level); end
        #1 reset = 0;
        model_reset();
        @(negedge clk);
        log_we = 1; log_addr = 16'h05AA; tick();
        log_we = 0; log_data = d; tick();
        n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset early_valid got %b want 0", tx_valid); end
        tick();
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (tx_valid !== 1'b1 || tx_data !== fbyte(16'h05AA, d, k)) begin
                n_fail++; $display("FAIL async_reset byte%0d got v=%b %h want v=1 %h", k, tx_valid, tx_data, fbyte(16'h05AA, d, k));
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_data;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            exp_data = (mcur.size() != 0) ? mcur[0] : 8'h00;
            n_chk++;
            if (tx_valid !== (mcur.size() != 0) || tx_data !== exp_data) begin
                n_fail++;
                if (n_fail < 30) $display("FAIL random tx c=%0d got v=%b %h want v=%b %h", c, tx_valid, tx_data, mcur.size() != 0, exp_data);
            end
            n_chk++;
            if (fifo_level !== LVL_W'(mq.size())) begin
                n_fail++;
                if (n_fail < 30) $display("FAIL random level c=%0d got %0d want %0d", c, fifo_level, mq.size());
            end
            n_chk++;
            if (drop_cnt !== 16'(m_drop) || overflow !== m_ovf) begin
                n_fail++;
                if (n_fail < 30) $display("FAIL random drops c=%0d got %0d/%b want %0d/%b", c, drop_cnt, overflow, m_drop, m_ovf);
            end
            clr      = ($urandom_range(0, 299) == 0);
            log_we   = !clr && ($urandom_range(0, (c < 1500) ? 9 : 3) == 0);
            tx_ready = ($urandom_range(0, 3) != 0);
            log_addr = 16'($urandom);
            log_data = {5'($urandom), 32'($urandom)};
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/log_drain.md
# log_drain

Byte-stream drain for the attestation event logger. It sits directly downstream of the logger and captures each 37-bit log entry together with its 16-bit slot address into an entry FIFO. Each entry is then serialized as an 8-byte frame over a valid/ready byte interface toward the debug/export path. Overflow is counted rather than back-pressured, because the logger cannot stall.

## Interface
- DEPTH, 8: FIFO depth in entries; must be a power of two, at least 2.
- LVL_W, 4: width of the level output; equals log2(DEPTH)+1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- log_we  in  1  logger write strobe for the current cycle.
- log_addr  in  16  logger write address; valid in the cycle log_we is high.
- log_data  in  37  logger entry; valid in the cycle after log_we is high.
- clr  in  1  synchronous clear of FIFO, drop counter and overflow flag.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_ready  in  1  consumer accepts the byte when tx_valid and tx_ready are both high.
- fifo_level  out  LVL_W  number of entries currently stored, 0..DEPTH.
- drop_cnt  out  16  entries dropped on full FIFO; saturates at 0xFFFF.
- overflow  out  1  sticky flag, set on the first drop.

## Operation
- **Capture stage**
  - In cycle N with log_we=1, register we_d=1 and addr_d=log_addr.
  - In cycle N+1 with we_d=1, form entry {addr_d, log_data} (53 bits) and push it at the end of N+1.
  - log_we every cycle is legal; each cycle produces one push.
- **FIFO**
  - Circular buffer, DEPTH×53, write and read pointers one bit wider than the index.
  - Full when the pointers differ only in the MSB. Empty when the pointers are equal.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - A rejected push increments drop_cnt (saturating) and sets overflow. The stored contents are unchanged.
- **Serializer FSM:** states IDLE and SEND; byte index idx is 3 bits.
  - IDLE with FIFO non-empty: pop the head into shreg, set idx=0, go to SEND.
  - SEND: tx_valid=1. Byte order by idx:
    - idx 0: 0xA5 sync.
    - idx 1: addr[15:8].
    - idx 2: addr[7:0].
    - idx 3: {3'b000, data[36:32]}.
    - idx 4: data[31:24].
    - idx 5: data[23:16].
    - idx 6: data[15:8].
    - idx 7: data[7:0].
  - On each handshake, idx increments.
  - On the handshake at idx 7:
    - If the FIFO is non-empty, pop the next entry, set idx=0 and stay in SEND (gapless frames).
    - Otherwise go to IDLE.
- **tx_data and tx_valid**
  - Both are registered outputs.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
- **clr**
  - Empties the FIFO and zeroes drop_cnt and overflow.
  - Discards any entry in the capture stage.
  - A frame already loaded into the serializer completes normally.
  - A push and clr in the same cycle: clr wins, and the push is not counted as a drop.
- fifo_level is write pointer minus read pointer, registered along with the pointers.

## Timing
- Reset values:
  - tx_data=0x00, tx_valid=0, fifo_level=0, drop_cnt=0, overflow=0.
  - FSM in IDLE; we_d=0; both pointers 0.
- Latency with the FIFO empty, serializer idle and tx_ready=1:
  - log_we in cycle N.
  - Push at the end of N+1.
  - Pop at the end of N+2.
  - tx_valid=1 with byte 0xA5 in N+3.
  - The last byte of the frame appears in N+10.
- Throughput: one frame per 8 cycles with tx_ready held high. Sustained log_we above 1/8 duty eventually overflows.
- Simultaneous push and pop while full: both occur, and fifo_level stays at DEPTH.
- drop_cnt at 0xFFFF stays at 0xFFFF; overflow stays 1.
- Reset asserted mid-frame: all state is cleared immediately, and tx_valid falls asynchronously.

## Test plan
- **Single entry:** reset, then log_we with log_addr=0x0003 and log_data=37'h1_2345_6789 one cycle later, tx_ready=1.
  - Required: 0xA5 in N+3, then 00 03 01 23 45 67 89.
  - fifo_level returns to 0.
- **Back-pressure:** hold tx_ready=0 for 5 cycles after tx_valid rises.
  - Required: tx_data stays 0xA5 and tx_valid stays 1.
  - The frame resumes intact after release.
- **Overflow:** tx_ready=0, then 11 consecutive log_we pulses with DEPTH=8.
  - Required: after the first pop fills the serializer, fifo_level=8, drop_cnt=2, overflow=1.
  - The drained frames carry the first 9 addresses in order.
- **Full with simultaneous pop:** with the FIFO full, complete the final handshake of a frame while a push arrives.
  - Required: no drop is counted and fifo_level stays at 8.
- **Clear during a frame:** assert clr at idx 3 of a frame with 4 entries queued.
  - Required: the current frame finishes its 8 bytes, then tx_valid=0.
  - fifo_level=0, drop_cnt=0.
- **Asynchronous reset mid-frame:** pulse reset between clock edges.
  - Required: tx_valid=0 and fifo_level=0 without waiting for a clock edge.
  - A following entry produces a normal frame with latency N+3.
